// File: rtl/instruction_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetcher
// Brief    : Owns the PC, issues one word-fetch at a time and hands each
//            returned instruction to the instruction queue as {pc, inst}.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetcher #(
    parameter int                    INST_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 17,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             rdy,
    output logic                             mem_req_valid,
    output logic [ADDR_WIDTH-1:0]            mem_req_addr,
    input  logic                             mem_req_ready,
    input  logic                             mem_resp_valid,
    input  logic [INST_WIDTH-1:0]            mem_resp_data,
    output logic                             inst_queue_entry_valid,
    output logic [ADDR_WIDTH+INST_WIDTH-1:0] inst_queue_entry,
    input  logic                             inst_queue_ready,
    input  logic                             redirect_valid,
    input  logic [ADDR_WIDTH-1:0]            redirect_pc
);

    localparam int                    c_ENTRY_W = ADDR_WIDTH + INST_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_PC_STEP = ADDR_WIDTH'(4);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_pc;
    logic                    r_discard;
    logic                    r_entry_valid;
    logic [c_ENTRY_W-1:0]    r_entry;

    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   w_pc_nxt;
    logic                    w_discard_nxt;
    logic                    w_entry_valid_nxt;
    logic [c_ENTRY_W-1:0]    w_entry_nxt;
    logic [ADDR_WIDTH-1:0]   w_redirect_pc;
    logic                    w_unused_bits;

    assign w_redirect_pc = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    assign w_unused_bits = &{1'b0, redirect_pc[1:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_REQ;
            r_pc          <= RESET_PC;
            r_discard     <= 1'b0;
            r_entry_valid <= 1'b0;
            r_entry       <= '0;
        end else if (rdy) begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_discard     <= w_discard_nxt;
            r_entry_valid <= w_entry_valid_nxt;
            r_entry       <= w_entry_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_discard_nxt     = r_discard;
        w_entry_valid_nxt = r_entry_valid;
        w_entry_nxt       = r_entry;

        if (redirect_valid) begin
            // Redirect wins over any handshake; a fetch already accepted at
            // the old PC must still be drained, hence the discard flag.
            w_pc_nxt          = w_redirect_pc;
            w_entry_valid_nxt = 1'b0;
            case (r_state)
                S_REQ: begin
                    if (mem_req_ready) begin
                        w_state_nxt   = S_WAIT;
                        w_discard_nxt = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        w_state_nxt   = S_REQ;
                        w_discard_nxt = 1'b0;
                    end else begin
                        w_discard_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_REQ;
                end
            endcase
        end else begin
            case (r_state)
                S_REQ: begin
                    if (mem_req_ready) begin
                        w_state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        if (r_discard) begin
                            w_discard_nxt = 1'b0;
                            w_state_nxt   = S_REQ;
                        end else begin
                            w_entry_nxt       = {r_pc, mem_resp_data};
                            w_entry_valid_nxt = 1'b1;
                            w_pc_nxt          = r_pc + c_PC_STEP;
                            w_state_nxt       = S_HOLD;
                        end
                    end
                end
                default: begin
                    if (inst_queue_ready) begin
                        w_entry_valid_nxt = 1'b0;
                        w_state_nxt       = S_REQ;
                    end
                end
            endcase
        end
    end

    assign mem_req_valid          = (r_state == S_REQ);
    assign mem_req_addr           = r_pc;
    assign inst_queue_entry_valid = r_entry_valid;
    assign inst_queue_entry       = r_entry;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetcher
// Brief    : Directed scoreboard bench for instruction_fetcher.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetcher;

    localparam int AW = 17;
    localparam int IW = 32;
    localparam int EW = AW + IW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rdy = 1'b1;
    logic          mem_req_ready = 1'b0;
    logic          mem_resp_valid = 1'b0;
    logic [IW-1:0] mem_resp_data = '0;
    logic          inst_queue_ready = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;

    logic          mem_req_valid, entry_valid;
    logic [AW-1:0] mem_req_addr;
    logic [EW-1:0] entry;
    logic          r100_req_valid, r100_entry_valid;
    logic [AW-1:0] r100_req_addr;
    logic [EW-1:0] r100_entry;

    logic [AW-1:0] exp_addrs[$];
    logic [EW-1:0] exp_entries[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int prev_acc = 0;

    instruction_fetcher #(.INST_WIDTH(IW), .ADDR_WIDTH(AW), .RESET_PC(17'h0)) u_dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data),
        .inst_queue_entry_valid(entry_valid), .inst_queue_entry(entry),
        .inst_queue_ready(inst_queue_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    instruction_fetcher #(.INST_WIDTH(IW), .ADDR_WIDTH(AW), .RESET_PC(17'h100)) u_dut_rst (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .mem_req_valid(r100_req_valid), .mem_req_addr(r100_req_addr),
        .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data),
        .inst_queue_entry_valid(r100_entry_valid), .inst_queue_entry(r100_entry),
        .inst_queue_ready(inst_queue_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Request and queue handshakes complete on the following rising edge.
    always @(negedge clk) begin
        if (rst_n && rdy && mem_req_valid && mem_req_ready) begin
            if (exp_addrs.size() == 0) check("req_unexpected", {47'b0, mem_req_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
            else                       check("req_addr", {47'b0, mem_req_addr}, {47'b0, exp_addrs.pop_front()});
        end
        if (rst_n && rdy && entry_valid && inst_queue_ready && !redirect_valid) begin
            if (exp_entries.size() == 0) check("entry_unexpected", {15'b0, entry}, 64'hFFFF_FFFF_FFFF_FFFF);
            else                         check("entry", {15'b0, entry}, {15'b0, exp_entries.pop_front()});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; rdy = 1'b1; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        redirect_valid = 1'b0; inst_queue_ready = 1'b0;
        step(); step();
        rst_n = 1'b1;
    endtask

    task automatic do_req();
        int n = 0;
        while (!mem_req_valid && n < 20) begin
            step();
            n++;
        end
        check("req_valid_timeout", {63'b0, mem_req_valid}, 64'd1);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        prev_acc = acc_cyc;
        acc_cyc = cyc;
    endtask

    task automatic do_resp(input logic [IW-1:0] d, input int delay);
        repeat (delay) step();
        mem_resp_valid = 1'b1;
        mem_resp_data  = d;
        step();
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [IW-1:0] d, input bit with_entry);
        exp_addrs.push_back(a);
        if (with_entry) exp_entries.push_back({a, d});
    endtask

    initial begin
        logic [IW-1:0] sdata [3];
        sdata[0] = 32'h0000_0013;
        sdata[1] = 32'h0010_0093;
        sdata[2] = 32'h0020_0113;

        // Reset
        do_reset();
        rst_n = 1'b0; step(); step();
        check("rst_entry_valid", {63'b0, r100_entry_valid}, 64'd0);
        check("rst_entry", {15'b0, r100_entry}, 64'd0);
        check("rst_req_valid", {63'b0, r100_req_valid}, 64'd1);
        check("rst_req_addr", {47'b0, r100_req_addr}, 64'h100);
        rst_n = 1'b1;

        // Streaming
        do_reset();
        inst_queue_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(AW'(4 * i), sdata[i], 1'b1);
            do_req();
            if (i > 0) check("stream_gap", 64'(acc_cyc - prev_acc), 64'd3);
            do_resp(sdata[i], 0);
            check("stream_entry_valid", {63'b0, entry_valid}, 64'd1);
        end
        step(); step();

        // Backpressure
        do_reset();
        push(17'h0, 32'hDEAD_0001, 1'b1);
        do_req();
        do_resp(32'hDEAD_0001, 0);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {63'b0, entry_valid}, 64'd1);
            check("bp_entry", {15'b0, entry}, {15'b0, 17'h0, 32'hDEAD_0001});
            check("bp_req_valid", {63'b0, mem_req_valid}, 64'd0);
            step();
        end
        inst_queue_ready = 1'b1;
        step();
        check("bp_next_addr", {47'b0, mem_req_addr}, 64'h4);
        push(17'h4, 32'hDEAD_0002, 1'b1);
        do_req();
        do_resp(32'hDEAD_0002, 1);
        step();

        // Redirect in WAIT
        do_reset();
        inst_queue_ready = 1'b1;
        push(17'h0, 32'h1111_0000, 1'b1); do_req(); do_resp(32'h1111_0000, 0);
        push(17'h4, 32'h1111_0004, 1'b1); do_req(); do_resp(32'h1111_0004, 0);
        push(17'h8, 32'h0, 1'b0);
        do_req();
        redirect_valid = 1'b1; redirect_pc = 17'h40;
        step();
        redirect_valid = 1'b0;
        check("rw_req_valid_wait", {63'b0, mem_req_valid}, 64'd0);
        do_resp(32'hBAD0_0008, 1);
        check("rw_no_entry", {63'b0, entry_valid}, 64'd0);
        check("rw_req_valid", {63'b0, mem_req_valid}, 64'd1);
        check("rw_next_addr", {47'b0, mem_req_addr}, 64'h40);
        push(17'h40, 32'h2222_0040, 1'b1);
        do_req(); do_resp(32'h2222_0040, 0);
        step();

        // Redirect in HOLD with simultaneous ready
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 17'h10;
        step();
        redirect_valid = 1'b0;
        check("rh_redirect_addr", {47'b0, mem_req_addr}, 64'h10);
        push(17'h10, 32'h0, 1'b0);
        do_req(); do_resp(32'h3333_0010, 0);
        check("rh_held", {63'b0, entry_valid}, 64'd1);
        redirect_valid = 1'b1; redirect_pc = 17'h23; inst_queue_ready = 1'b1;
        step();
        redirect_valid = 1'b0;
        check("rh_dropped", {63'b0, entry_valid}, 64'd0);
        check("rh_next_addr", {47'b0, mem_req_addr}, 64'h20);
        push(17'h20, 32'h3333_0020, 1'b1);
        do_req(); do_resp(32'h3333_0020, 0);
        step();

        // Wrap and rdy stall
        do_reset();
        inst_queue_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 17'h1FFFC;
        step();
        redirect_valid = 1'b0;
        push(17'h1FFFC, 32'h4444_FFFC, 1'b1);
        do_req();
        rdy = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = 32'hBAD0_BAD0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_req_valid", {63'b0, mem_req_valid}, 64'd0);
            check("stall_entry_valid", {63'b0, entry_valid}, 64'd0);
        end
        mem_resp_valid = 1'b0;
        rdy = 1'b1;
        do_resp(32'h4444_FFFC, 0);
        check("wrap_entry", {15'b0, entry}, {15'b0, 17'h1FFFC, 32'h4444_FFFC});
        step();
        check("wrap_next_addr", {47'b0, mem_req_addr}, 64'h0);
        check("wrap_next_valid", {63'b0, mem_req_valid}, 64'd1);
        step();

        check("sb_addr_empty", 64'(exp_addrs.size()), 64'd0);
        check("sb_entry_empty", 64'(exp_entries.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
